// File: rtl/single_pkg.sv
// Shared IEEE-754 single-precision definitions for the float utility chain
// (fractional-part and integer-part extractors).
package single_pkg;

  localparam int SINGLE_BIAS    = 127;
  localparam int SINGLE_MANT_W  = 23;
  localparam int SINGLE_EXP_MAX = 255;
  localparam logic [31:0] SINGLE_QNAN = 32'h7FC00000;

  localparam logic [7:0] EXP_BIAS8     = 8'(SINGLE_BIAS);
  localparam logic [7:0] EXP_MAX8      = 8'(SINGLE_EXP_MAX);
  // Smallest biased exponent at which every mantissa bit is integral.
  localparam logic [7:0] EXP_INTEGRAL8 = 8'(SINGLE_BIAS + SINGLE_MANT_W);

  typedef enum logic [1:0] {
    CLS_NAN,
    CLS_ZERO,
    CLS_PASS,
    CLS_NORM
  } single_cls_t;

  typedef struct packed {
    logic                     sign;
    logic [7:0]               exp;
    logic [SINGLE_MANT_W-1:0] mant;
  } single_t;

  // Mantissa bits below the binary point for unbiased exponent k (0..22).
  function automatic logic [SINGLE_MANT_W-1:0] frac_mask(input logic [4:0] k);
    return {SINGLE_MANT_W{1'b1}} >> k;
  endfunction

endpackage

// File: rtl/single_lzc.sv
// Combinational 23-bit leading-zero counter; returns 23 for an all-zero input.
module single_lzc
  import single_pkg::*;
(
  input  logic [SINGLE_MANT_W-1:0] val_i,
  output logic [4:0]               lz_o
);

  // Ascending scan so the highest set bit is the last to write the result.
  always_comb begin
    lz_o = 5'(SINGLE_MANT_W);
    for (int i = 0; i < SINGLE_MANT_W; i++) begin
      if (val_i[i]) lz_o = 5'(SINGLE_MANT_W - 1 - i);
    end
  end

endmodule

// File: rtl/single_fractional_part.sv
// frac(a) = a - trunc(a) for IEEE-754 single, exact, sign kept; 3-stage pipeline
// (classify/mask, LZC, normalize/pack), 3-cycle latency, valid/ready with full-rate stall chain.
module single_fractional_part
  import single_pkg::*;
#(
  parameter int          TAG_W       = 4,
  parameter bit          SIGNED_ZERO = 1'b1,
  parameter logic [31:0] NAN_VALUE   = SINGLE_QNAN
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      c,
  output logic [TAG_W-1:0] out_tag
);

  logic                     s1_vld_q, s2_vld_q, out_vld_q;
  single_cls_t              s1_cls_q, s2_cls_q, s1_cls_d;
  single_t                  s1_val_q, s2_val_q, s1_val_d;
  logic [TAG_W-1:0]         s1_tag_q, s2_tag_q, out_tag_q;
  logic [4:0]               s2_lz_q, s2_lz_d;
  logic [31:0]              c_q, c_d;
  single_t                  a_s;
  logic [SINGLE_MANT_W-1:0] m_masked;
  logic [7:0]               norm_exp;
  logic [SINGLE_MANT_W-1:0] norm_mant;
  logic                     out_rdy, s2_rdy;

  // Each stage may load when it is empty or its contents move on this cycle.
  assign out_rdy  = !out_vld_q | out_ready;
  assign s2_rdy   = !s2_vld_q | out_rdy;
  assign in_ready = !s1_vld_q | s2_rdy;

  assign a_s      = a;
  assign m_masked = a_s.mant & frac_mask(5'(a_s.exp - EXP_BIAS8));

  always_comb begin
    s1_cls_d = CLS_PASS;
    s1_val_d = a_s;
    if (a_s.exp == EXP_MAX8) begin
      s1_cls_d = (a_s.mant != '0) ? CLS_NAN : CLS_ZERO;
    end else if (a_s.exp >= EXP_INTEGRAL8) begin
      s1_cls_d = CLS_ZERO;
    end else if (a_s.exp >= EXP_BIAS8) begin
      s1_val_d.mant = m_masked;
      s1_cls_d      = (m_masked == '0) ? CLS_ZERO : CLS_NORM;
    end
  end

  single_lzc u_lzc (
    .val_i (s1_val_q.mant),
    .lz_o  (s2_lz_d)
  );

  // Leading one at p = 22 - lz: exponent e + p - 23, shift the hidden bit out.
  assign norm_exp  = s2_val_q.exp - 8'd1 - {3'b000, s2_lz_q};
  assign norm_mant = s2_val_q.mant << (s2_lz_q + 5'd1);

  always_comb begin
    c_d = {s2_val_q.sign, norm_exp, norm_mant};
    case (s2_cls_q)
      CLS_NAN:  c_d = NAN_VALUE;
      CLS_ZERO: c_d = {s2_val_q.sign & SIGNED_ZERO, 31'b0};
      CLS_PASS: c_d = s2_val_q;
      default:  c_d = {s2_val_q.sign, norm_exp, norm_mant};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_vld_q  <= 1'b0;
      s1_cls_q  <= CLS_NAN;
      s1_val_q  <= '0;
      s1_tag_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_cls_q  <= CLS_NAN;
      s2_val_q  <= '0;
      s2_lz_q   <= '0;
      s2_tag_q  <= '0;
      out_vld_q <= 1'b0;
      c_q       <= '0;
      out_tag_q <= '0;
    end else begin
      if (in_ready) s1_vld_q <= in_valid;
      if (in_valid && in_ready) begin
        s1_cls_q <= s1_cls_d;
        s1_val_q <= s1_val_d;
        s1_tag_q <= in_tag;
      end
      if (s2_rdy) s2_vld_q <= s1_vld_q;
      if (s1_vld_q && s2_rdy) begin
        s2_cls_q <= s1_cls_q;
        s2_val_q <= s1_val_q;
        s2_lz_q  <= s2_lz_d;
        s2_tag_q <= s1_tag_q;
      end
      if (out_rdy) out_vld_q <= s2_vld_q;
      if (s2_vld_q && out_rdy) begin
        c_q       <= c_d;
        out_tag_q <= s2_tag_q;
      end
    end
  end

  assign out_valid = out_vld_q;
  assign c         = c_q;
  assign out_tag   = out_tag_q;

endmodule
